dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and access sequencer for the byte-addressable, big-endian data memory. It shares the single memory port (`memwrite`, `address`, `write_data`, `read_data`) between the CPU load/store path (port 0) and the DMA/debug loader (port 1). Arbitration is round-robin. Every access runs through a fixed three-state sequence with a response handshake. The block checks word alignment and range, so an illegal request never reaches the memory.

## Interface
- `MEM_BYTES`, 1024: memory size in bytes. The legal address range is 0 to MEM_BYTES-4.
- `clk`  in  1  the single clock. All state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `m0_req` / `m1_req`  in  1  access request. Held high until granted.
- `m0_we` / `m1_we`  in  1  1 = write, 0 = read. Sampled with the grant.
- `m0_addr` / `m1_addr`  in  32  byte address. Sampled with the grant.
- `m0_wdata` / `m1_wdata`  in  32  write data. Sampled with the grant.
- `m0_gnt` / `m1_gnt`  out  1  combinational grant pulse. The request is accepted in this cycle.
- `m0_rvalid` / `m1_rvalid`  out  1  completion pulse, 1 cycle long. Issued for reads and writes.
- `m0_rdata` / `m1_rdata`  out  32  read data. Valid only while the matching rvalid is high.
- `m0_err` / `m1_err`  out  1  the access was rejected. Valid only while the matching rvalid is high.
- `mem_we`  out  1  drives `memwrite` on the memory.
- `mem_addr`  out  32  drives `address`.
- `mem_wdata`  out  32  drives `write_data`.
- `mem_rdata`  in  32  driven from `read_data`, which is combinational.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- **IDLE**
  - If any request is high, assert exactly one gnt.
  - On the grant, latch the winner's id, we, addr and wdata, then go to ACCESS.
  - With no request, stay in IDLE.
- **Arbitration**
  - A single requester always wins.
  - When both request, the winner is the port that was not granted last.
  - The `last` bit updates on every grant. Its reset value is 1, so port 0 wins the first tie.
- **ACCESS**
  - Drive `mem_addr` and `mem_wdata` from the latched values.
  - Drive `mem_we` from the latched we, high for this one cycle only.
  - A write commits at the closing edge.
  - A read captures `mem_rdata` into the response register at the closing edge.
  - Then go to RESP.
- **Error path**
  - An access is in error when addr[1:0] is nonzero or addr is greater than MEM_BYTES-4.
  - On error, ACCESS keeps `mem_we`=0 and `mem_addr`=0.
  - The response carries err=1 and rdata=0.
- **RESP**
  - Pulse rvalid for the latched id, with its rdata and err.
  - For a write, rdata=0.
  - Go to IDLE.
- **Idle outputs:** outside ACCESS, `mem_we`, `mem_addr` and `mem_wdata` are 0. Outputs for the non-responding port are 0.
- **Requests arriving in ACCESS or RESP:** they are held off (no gnt) and arbitrated on return to IDLE.
- **Reset (async)**
  - State goes to IDLE, latches clear and `last`=1.
  - All outputs go to 0 immediately.
  - A write in ACCESS that is interrupted by reset before its edge is not committed.
  - A pending response is dropped.

## Timing
- Cycle 0 (IDLE, req high): gnt is high in the same cycle.
- Cycle 1 (ACCESS): the memory port is active.
- Cycle 2 (RESP): rvalid is high.
- Cycle 3: IDLE. A new grant is possible in this cycle.
- Latency is 2 cycles from grant to rvalid. Peak throughput is 1 access per 3 cycles, shared between the two ports.
- gnt is combinational from state, req and `last`. All other outputs are registered or decoded from state only, with no input-to-output path.
- Requester side: deassert req the cycle after gnt, or keep it high to queue the next access. A held req is re-arbitrated in the next IDLE.

## Test plan
- **Reset:** with rst_n=0, every output is 0. Release reset with no requests: the block stays in IDLE and `mem_we` stays 0.
- **Single write then read**
  - Port 0 writes 0xDEADBEEF to 0x10: gnt in cycle 0, `mem_we`=1 only in cycle 1, m0_rvalid in cycle 2 with err=0.
  - Port 0 then reads 0x10: m0_rdata=0xDEADBEEF, and bytes 0x10..0x13 are DE, AD, BE, EF.
- **Tie fairness:** both ports request continuously with reads. Grant order is 0,1,0,1. Each grant is 3 cycles after the previous one.
- **Errors**
  - Port 1 writes to 0x12: m1_rvalid with err=1 and rdata=0, `mem_we` never rises, and memory is unchanged.
  - A read at 0x3FD with MEM_BYTES=1024 is also rejected with err=1.
- **Late arrival:** port 1 raises req while port 0's access is in ACCESS. No gnt until RESP completes, then port 1 is granted in the first IDLE cycle.
- **Reset mid-write:** pull rst_n low during ACCESS of a write to 0x20, before the edge. The word at 0x20 keeps its old value, no rvalid is issued, and the first grant after reset goes to port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin arbiter and access sequencer for the big-endian,
//            byte-addressable data memory. The memory port is shared between
//            port 0 (CPU load/store) and port 1 (DMA/debug loader). Each
//            access walks IDLE -> ACCESS -> RESP. A misaligned or
//            out-of-range request is answered with err=1 and never reaches
//            the memory.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            mN_req/we/addr/wdata requester inputs, sampled with the grant
//            mN_gnt              combinational grant (IDLE only)
//            mN_rvalid/rdata/err one-cycle response in RESP
//            mem_we/addr/wdata   memory port, active only in ACCESS
//            mem_rdata           combinational read data from memory
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        last;      // port granted most recently
  logic        id_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        any_req;
  logic        winner;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        addr_err;

  // On a tie the port that was not granted last wins.
  always_comb begin
    any_req   = m0_req | m1_req;
    winner    = (m0_req & m1_req) ? ~last : m1_req;
    sel_we    = winner ? m1_we    : m0_we;
    sel_addr  = winner ? m1_addr  : m0_addr;
    sel_wdata = winner ? m1_wdata : m0_wdata;
    addr_err  = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);
  end

  always_comb begin
    state_next = state;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    m0_err     = 1'b0;
    m1_err     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        // rst_n gates the grant so every output reads 0 while reset is held.
        if (any_req && rst_n) begin
          m0_gnt     = ~winner;
          m1_gnt     = winner;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // A rejected access leaves the memory port completely idle.
        if (!err_q) begin
          mem_we    = we_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
        end
        state_next = RESP;
      end
      RESP: begin
        if (id_q) begin
          m1_rvalid = 1'b1;
          m1_rdata  = rdata_q;
          m1_err    = err_q;
        end else begin
          m0_rvalid = 1'b1;
          m0_rdata  = rdata_q;
          m0_err    = err_q;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_req) begin
        id_q    <= winner;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        err_q   <= addr_err;
        last    <= winner;
      end
      // Writes and rejected accesses respond with zero data.
      if (state == ACCESS) begin
        rdata_q <= (!we_q && !err_q) ? mem_rdata : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter with a byte-wide
//            big-endian memory model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  mem  [0:MEM_BYTES-1];
  logic [7:0]  gold [0:MEM_BYTES-1];

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t sbq[$];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Big-endian memory: combinational read, write at the rising edge.
  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 32'(MEM_BYTES - 4))
      mem_rdata = {mem[mem_addr[9:0]], mem[mem_addr[9:0] + 10'd1],
                   mem[mem_addr[9:0] + 10'd2], mem[mem_addr[9:0] + 10'd3]};
  end

  always @(posedge clk) begin
    if (mem_we && mem_addr <= 32'(MEM_BYTES - 4)) begin
      mem[mem_addr[9:0]]         <= mem_wdata[31:24];
      mem[mem_addr[9:0] + 10'd1] <= mem_wdata[23:16];
      mem[mem_addr[9:0] + 10'd2] <= mem_wdata[15:8];
      mem[mem_addr[9:0] + 10'd3] <= mem_wdata[7:0];
    end
  end

  function automatic logic [31:0] gword(input logic [31:0] a);
    return {gold[a[9:0]], gold[a[9:0] + 10'd1], gold[a[9:0] + 10'd2], gold[a[9:0] + 10'd3]};
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {mem[a[9:0]], mem[a[9:0] + 10'd1], mem[a[9:0] + 10'd2], mem[a[9:0] + 10'd3]};
  endfunction

  // Reference model: computes the response and updates the golden image.
  function automatic exp_t predict(input bit port, input bit we,
                                   input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.port  = port;
    e.err   = (addr[1:0] != 2'b00) || (addr > 32'(MEM_BYTES - 4));
    e.rdata = '0;
    if (!e.err) begin
      if (we) begin
        gold[addr[9:0]]         = wdata[31:24];
        gold[addr[9:0] + 10'd1] = wdata[23:16];
        gold[addr[9:0] + 10'd2] = wdata[15:8];
        gold[addr[9:0] + 10'd3] = wdata[7:0];
      end else begin
        e.rdata = gword(addr);
      end
    end
    return e;
  endfunction

  function automatic logic [10:0] outs();
    return {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_we,
            |m0_rdata, |m1_rdata, |mem_addr, |mem_wdata};
  endfunction

  task automatic drive(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  // Advances cycle by cycle until a response appears (bounded).
  task automatic wait_resp(input bit drop, output bit got, output bit port,
                           output logic [31:0] rdata, output bit err, output bit active);
    got = 0; port = 0; rdata = '0; err = 0; active = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (drop && c == 0) begin m0_req = 1'b0; m1_req = 1'b0; end
      #1;
      if (mem_we === 1'b1 || mem_addr !== 32'd0) active = 1;
      if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) begin
        got   = 1;
        port  = (m1_rvalid === 1'b1);
        rdata = port ? m1_rdata : m0_rdata;
        err   = port ? m1_err : m0_err;
      end
    end
  endtask

  task automatic test_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    #2;
    n_checks++;
    if (outs() !== 11'd0) begin n_fail++; $display("FAIL reset_outs: got %b expected 0", outs()); end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (outs() !== 11'd0) begin n_fail++; $display("FAIL idle_outs[%0d]: got %b expected 0", c, outs()); end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    bit got, port, err, act;
    logic [31:0] rd;
    @(negedge clk); drive(0, 1, 32'h10, 32'hDEADBEEF); #1;
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL wr_gnt: got %b expected 10", {m0_gnt, m1_gnt}); end
    sbq.push_back(predict(0, 1, 32'h10, 32'hDEADBEEF));
    @(negedge clk); m0_req = 1'b0; #1;
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h10, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wr_access: got we=%b a=%h d=%h expected 1/10/deadbeef", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk); #1;
    n_checks++;
    if (m0_rvalid !== 1'b1 || mem_we !== 1'b0 || sbq.size() == 0) begin
      n_fail++; $display("FAIL wr_rvalid: got rvalid=%b we=%b expected 1/0", m0_rvalid, mem_we);
    end else begin
      e = sbq.pop_front();
      n_checks++;
      if ({m0_err, m0_rdata} !== {e.err, e.rdata}) begin
        n_fail++; $display("FAIL wr_resp: got err=%b rd=%h expected %b/%h", m0_err, m0_rdata, e.err, e.rdata);
      end
    end
    @(negedge clk); drive(0, 0, 32'h10, 32'h0); #1;
    n_checks++;
    if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b expected 1", m0_gnt); end
    sbq.push_back(predict(0, 0, 32'h10, 32'h0));
    wait_resp(1, got, port, rd, err, act);
    e = sbq.pop_front();
    n_checks++;
    if (!got || port != e.port || err != e.err || rd !== e.rdata || rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_resp: got v=%b p=%b err=%b rd=%h expected 1/0/0/%h", got, port, err, rd, e.rdata);
    end
    n_checks++;
    if ({mem[16], mem[17], mem[18], mem[19]} !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_bytes: got %h expected deadbeef", {mem[16], mem[17], mem[18], mem[19]});
    end
  endtask

  task automatic test_errors();
    exp_t e;
    bit got, port, err, act;
    logic [31:0] rd;
    @(negedge clk); drive(1, 1, 32'h12, 32'h12345678); #1;
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin n_fail++; $display("FAIL err_wr_gnt: got %b expected 01", {m0_gnt, m1_gnt}); end
    sbq.push_back(predict(1, 1, 32'h12, 32'h12345678));
    wait_resp(1, got, port, rd, err, act);
    e = sbq.pop_front();
    n_checks++;
    if (!got || port !== 1'b1 || err !== 1'b1 || rd !== 32'd0 || act || e.err != 1'b1) begin
      n_fail++; $display("FAIL err_wr_resp: got v=%b p=%b err=%b rd=%h memact=%b expected 1/1/1/0/0", got, port, err, rd, act);
    end
    n_checks++;
    if (mword(32'h10) !== gword(32'h10) || mword(32'h14) !== gword(32'h14)) begin
      n_fail++; $display("FAIL err_wr_mem: got %h %h expected %h %h", mword(32'h10), mword(32'h14), gword(32'h10), gword(32'h14));
    end
    @(negedge clk); drive(1, 0, 32'h3FD, 32'h0); #1;
    n_checks++;
    if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL err_rd_gnt: got %b expected 1", m1_gnt); end
    sbq.push_back(predict(1, 0, 32'h3FD, 32'h0));
    wait_resp(1, got, port, rd, err, act);
    e = sbq.pop_front();
    n_checks++;
    if (!got || port !== 1'b1 || err !== e.err || rd !== e.rdata || act) begin
      n_fail++; $display("FAIL err_rd_resp: got v=%b p=%b err=%b rd=%h memact=%b expected 1/1/1/0/0", got, port, err, rd, act);
    end
  endtask

  task automatic test_fairness();
    int ng = 0;
    int order [4];
    int gcyc [4];
    exp_t e;
    @(negedge clk);
    drive(0, 0, 32'h10, 32'h0);
    drive(1, 0, 32'h40, 32'h0);
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (ng == 4) begin m0_req = 1'b0; m1_req = 1'b0; end
      #1;
      if (m0_gnt === 1'b1 || m1_gnt === 1'b1) begin
        if (ng < 4) begin
          order[ng] = (m1_gnt === 1'b1) ? 1 : 0;
          gcyc[ng]  = c;
          sbq.push_back(predict(m1_gnt === 1'b1, 0, (m1_gnt === 1'b1) ? 32'h40 : 32'h10, 32'h0));
        end
        ng++;
      end
      if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL fair_resp: got unexpected response expected none");
        end else begin
          e = sbq.pop_front();
          if ((m1_rvalid === 1'b1) != e.port || (e.port ? m1_rdata : m0_rdata) !== e.rdata
              || (e.port ? m1_err : m0_err) !== e.err) begin
            n_fail++; $display("FAIL fair_resp: got p=%b rd=%h expected p=%b rd=%h", m1_rvalid,
                               e.port ? m1_rdata : m0_rdata, e.port, e.rdata);
          end
        end
      end
      if (ng >= 4 && sbq.size() == 0) break;
    end
    n_checks++;
    if (ng != 4) begin n_fail++; $display("FAIL fair_count: got %0d expected 4", ng); end
    for (int i = 0; i < 4 && i < ng; i++) begin
      n_checks++;
      if (order[i] != (i % 2)) begin n_fail++; $display("FAIL fair_order[%0d]: got %0d expected %0d", i, order[i], i % 2); end
      if (i > 0) begin
        n_checks++;
        if (gcyc[i] - gcyc[i-1] != 3) begin
          n_fail++; $display("FAIL fair_spacing[%0d]: got %0d expected 3", i, gcyc[i] - gcyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_late_arrival();
    exp_t e;
    bit got, port, err, act;
    logic [31:0] rd;
    @(negedge clk); drive(0, 0, 32'h10, 32'h0); #1;
    n_checks++;
    if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL late_g0: got %b expected 1", m0_gnt); end
    sbq.push_back(predict(0, 0, 32'h10, 32'h0));
    @(negedge clk); m0_req = 1'b0; drive(1, 0, 32'h44, 32'h0); #1;
    n_checks++;
    if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL late_access_gnt: got %b expected 0", m1_gnt); end
    @(negedge clk); #1;
    n_checks++;
    if (m1_gnt !== 1'b0 || m0_rvalid !== 1'b1 || sbq.size() == 0) begin
      n_fail++; $display("FAIL late_resp: got gnt1=%b rvalid0=%b expected 0/1", m1_gnt, m0_rvalid);
    end else begin
      e = sbq.pop_front();
      n_checks++;
      if (m0_rdata !== e.rdata) begin n_fail++; $display("FAIL late_rdata0: got %h expected %h", m0_rdata, e.rdata); end
    end
    @(negedge clk); #1;
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin n_fail++; $display("FAIL late_g1: got %b expected 01", {m0_gnt, m1_gnt}); end
    sbq.push_back(predict(1, 0, 32'h44, 32'h0));
    wait_resp(1, got, port, rd, err, act);
    e = sbq.pop_front();
    n_checks++;
    if (!got || port !== 1'b1 || rd !== e.rdata || err !== e.err) begin
      n_fail++; $display("FAIL late_rdata1: got v=%b p=%b rd=%h expected 1/1/%h", got, port, rd, e.rdata);
    end
  endtask

  task automatic test_reset_mid_write();
    exp_t e;
    bit got, port, err, act;
    logic [31:0] rd;
    @(negedge clk); drive(0, 1, 32'h20, 32'hCAFEF00D); #1;
    n_checks++;
    if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_wr_gnt: got %b expected 1", m0_gnt); end
    @(negedge clk); m0_req = 1'b0; #1;
    n_checks++;
    if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_wr_access: got %b expected 1", mem_we); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 11'd0) begin n_fail++; $display("FAIL rst_async_outs: got %b expected 0", outs()); end
    @(negedge clk); #1;
    n_checks++;
    if (mword(32'h20) !== gword(32'h20) || outs() !== 11'd0) begin
      n_fail++; $display("FAIL rst_no_commit: got %h outs=%b expected %h outs=0", mword(32'h20), outs(), gword(32'h20));
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 32'h20, 32'h0);
    drive(1, 0, 32'h24, 32'h0);
    #1;
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL rst_first_gnt: got %b expected 10", {m0_gnt, m1_gnt}); end
    sbq.push_back(predict(0, 0, 32'h20, 32'h0));
    wait_resp(1, got, port, rd, err, act);
    e = sbq.pop_front();
    n_checks++;
    if (!got || port !== 1'b0 || rd !== e.rdata || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_readback: got v=%b p=%b rd=%h expected 1/0/%h", got, port, rd, e.rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i]  = 8'(i) ^ 8'h5A;
      gold[i] = 8'(i) ^ 8'h5A;
    end
    test_reset();
    test_write_read();
    test_errors();
    test_fairness();
    test_late_arrival();
    test_reset_mid_write();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
